// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: bounded-burst ownership, alternating tie-break,
// combinational grant onto a shared synchronous memory port.
module mem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic [2:0]    op0,
    input  logic [2:0]    op1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [2:0]    mem_op,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_P0,
        OWN_P1
    } owner_e;

    localparam logic [3:0] MaxBeat = 4'(MAX_BURST);

    owner_e     owner_q, owner_d;
    logic       last_q, last_d;
    logic [3:0] beat_q, beat_d;
    logic       rvalid0_q, rvalid0_d;
    logic       rvalid1_q, rvalid1_d;

    logic       g0, g1;
    logic       own_is1;
    logic       own_req;
    logic       oth_req;
    logic       at_max;
    logic       same_owner;

    // Grant decision; forced low while reset is asserted.
    always_comb begin
        g0      = 1'b0;
        g1      = 1'b0;
        own_is1 = (owner_q == OWN_P1);
        own_req = own_is1 ? req1 : req0;
        oth_req = own_is1 ? req0 : req1;
        at_max  = (beat_q >= MaxBeat);
        if (!reset) begin
            g0 = 1'b0;
            g1 = 1'b0;
        end else if (owner_q == OWN_NONE) begin
            if (req0 && req1) begin
                g0 = last_q;
                g1 = !last_q;
            end else begin
                g0 = req0;
                g1 = req1;
            end
        end else if (own_req && !(oth_req && at_max)) begin
            g0 = !own_is1;
            g1 = own_is1;
        end else if (oth_req) begin
            g0 = own_is1;
            g1 = !own_is1;
        end
    end

    always_comb begin
        owner_d    = owner_q;
        last_d     = last_q;
        beat_d     = beat_q;
        same_owner = (g0 && owner_q == OWN_P0) || (g1 && owner_q == OWN_P1);
        if (g0 || g1) begin
            last_d  = g1;
            owner_d = g1 ? OWN_P1 : OWN_P0;
            if (same_owner) begin
                beat_d = at_max ? MaxBeat : beat_q + 4'd1;
            end else begin
                beat_d = 4'd1;
            end
        end else begin
            owner_d = OWN_NONE;
            beat_d  = 4'd0;
        end
        rvalid0_d = g0 & ~we0;
        rvalid1_d = g1 & ~we1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner_q   <= OWN_NONE;
            last_q    <= 1'b1;
            beat_q    <= 4'd0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            owner_q   <= owner_d;
            last_q    <= last_d;
            beat_q    <= beat_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    // With no grant the command bus idles on port 0's inputs.
    assign gnt0      = g0;
    assign gnt1      = g1;
    assign mem_addr  = g1 ? addr1 : addr0;
    assign mem_wdata = g1 ? wdata1 : wdata0;
    assign mem_op    = g1 ? op1 : op0;
    assign mem_we    = (g0 & we0) | (g1 & we1);
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign rdata0    = mem_rdata;
    assign rdata1    = mem_rdata;

endmodule
